vid_stream_pkr: RTL and testbench
=================================

// Module: vid_stream_pkr
// PURPOSE
//  Downstream of the test-pattern generator. Converts raw video timing (hs, vs, vld, rgb) into a
//  ready/valid pixel stream: tuser marks start-of-frame (SOF), tlast marks end-of-line (EOL).
//  A FIFO absorbs sink backpressure. Measures active width/height and counts frames for status.
// PARAMETERS
//  PW         8   bits per colour component; pixel is 3*PW
//  FIFO_AW    4   FIFO address width; depth = 2**FIFO_AW entries of {tuser,tlast,pixel}
//  CNT_W      12  width of width/height measurement counters
// PORTS
//  clk          in   1        single clock for all logic
//  rst          in   1        synchronous, active-high reset
//  hs           in   1        hsync from generator (not used for framing; pass-through status only)
//  vs           in   1        vsync; rising edge = frame boundary
//  vld          in   1        active-pixel qualifier
//  rgb          in   3*PW     pixel, sampled only when vld=1
//  m_tdata      out  3*PW     output pixel
//  m_tvalid     out  1        output valid
//  m_tready     in   1        sink ready
//  m_tuser      out  1        SOF flag, meaningful with m_tvalid
//  m_tlast      out  1        EOL flag, meaningful with m_tvalid
//  act_width    out  CNT_W    pixels in last completed line
//  act_height   out  CNT_W    lines (EOL count) in last completed frame
//  frame_cnt    out  16       completed frames, wraps at 2**16
//  ovf_clr      in   1        clears ovf_sticky and drop_cnt
//  ovf_sticky   out  1        set when a pixel was dropped on a full FIFO
//  drop_cnt     out  16       dropped pixels, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: all outputs 0, FIFO emptied, state WAIT_VS, hold register empty. Reset mid-frame
//   discards buffered pixels; m_tvalid drops the cycle after rst is sampled high.
//  Edge detect: vs_rise = vs & ~vs_d; vld_fall = ~vld & vld_d (registered previous values).
//  FSM:
//   WAIT_VS  : ignore vld; on vs_rise -> WAIT_SOF (discards any partial first frame).
//   WAIT_SOF : first vld=1 cycle -> pixel tagged sof, -> ACTIVE.
//   ACTIVE   : on vs_rise -> WAIT_SOF; latch act_height <= line counter, clear it, frame_cnt++.
//  Lookahead: each accepted pixel enters a 1-entry hold register (pixel, sof). It is written to the
//   FIFO when the next vld=1 pixel arrives (tlast=0) or on vld_fall (tlast=1). An EOL write also
//   latches act_width <= pixel counter and increments the line counter.
//  Simultaneous vld_fall and vs_rise: EOL of held pixel is written first, then height latched
//   (height includes that line). vld=1 with vs_rise: vs handled, pixel is SOF of new frame.
//  FIFO write with FIFO full: entry dropped, ovf_sticky <= 1, drop_cnt++ (saturating); FSM and
//   measurement counters proceed unaffected. ovf_clr in same cycle as a drop: drop wins (stays set).
//  Output: m_tvalid = FIFO not empty; pop on m_tvalid & m_tready. m_tdata/tuser/tlast stable while
//   m_tvalid & ~m_tready. Simultaneous push and pop on full FIFO is allowed (no drop).
//  Latency: pixel sampled at cycle N (followed by a further vld pixel or vld_fall at N+1) is
//   visible on m_t* at N+2 with an empty FIFO.
//  Counters wrap modulo 2**CNT_W; a line of 0 pixels never produces EOL.
// STRUCTURE
//  vid_pkg.vh: localparams for FSM state encodings (WAIT_VS/WAIT_SOF/ACTIVE) and FIFO entry
//   layout offsets (TUSER_BIT, TLAST_BIT).
//  Sub-module vid_sfifo: synchronous FIFO (WIDTH, AW), full/empty flags, registered read data.
// TESTING
//  1. 4x3 frame, m_tready=1: 12 beats; beat0 tuser=1; beats 3,7,11 tlast=1; act_width=4, act_height=3.
//  2. Reset released mid-frame: no beats until next vs_rise; first output beat carries tuser=1.
//  3. m_tready=0 for 20 cycles, 8-px line, FIFO_AW=2: 4 beats kept, ovf_sticky=1, drop_cnt=4.
//  4. ovf_clr pulse after case 3: ovf_sticky=0, drop_cnt=0; next clean frame leaves them 0.
//  5. vld falls same cycle vs rises: last beat tlast=1, act_height counts that line, frame_cnt+1.
//  6. Random m_tready 50%, 3 frames 16x8: data order equals rgb order, frame_cnt=3, no drops.

Source files
------------

// File: rtl/vid_stream_pkr_pkg.sv
// Shared types and constants for the video stream packer.
package vid_stream_pkr_pkg;

   typedef enum logic [1:0] {
      WAIT_VS  = 2'd0,
      WAIT_SOF = 2'd1,
      ACTIVE   = 2'd2
   } vidState_t;

   // FIFO entry is {tuser, tlast, pixel}; flag offsets are relative to the pixel MSB+1
   localparam int unsigned TLAST_OFS = 0;
   localparam int unsigned TUSER_OFS = 1;
   localparam int unsigned FLAG_W    = 2;

   function automatic logic [15:0] satInc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/vid_stream_pkr_sfifo.sv
// Synchronous FIFO with registered first-word-fall-through read data and registered flags.
module vid_stream_pkr_sfifo #(
   parameter int unsigned WIDTH = 26,
   parameter int unsigned AW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wrData,
   input  logic             pop,
   output logic [WIDTH-1:0] rdData,
   output logic             valid,
   output logic             full
);

   localparam int unsigned DEPTH = 2**AW;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr, rdPtr;
   logic [AW:0]      count, countNxt;
   logic             pushOk, popOk;

   assign popOk    = pop & valid;
   assign pushOk   = push & (~full | popOk);
   assign countNxt = count + (AW+1)'(pushOk) - (AW+1)'(popOk);

   always_ff @(posedge clk) begin
      if (pushOk) mem[wrPtr] <= wrData;
   end

   // rdData always shadows the head entry so the output is a plain register
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr  <= '0;
         rdPtr  <= '0;
         count  <= '0;
         valid  <= 1'b0;
         full   <= 1'b0;
         rdData <= '0;
      end else begin
         if (pushOk) wrPtr <= wrPtr + AW'(1);
         if (popOk)  rdPtr <= rdPtr + AW'(1);
         count <= countNxt;
         valid <= (countNxt != '0);
         full  <= (countNxt == (AW+1)'(DEPTH));
         if (popOk) begin
            if (count >= (AW+1)'(2)) rdData <= mem[rdPtr + AW'(1)];
            else if (pushOk)         rdData <= wrData;
         end else if (~valid & pushOk) begin
            rdData <= wrData;
         end
      end
   end

endmodule

// File: rtl/vid_stream_pkr.sv
// Packs raw video timing into a ready/valid pixel stream with SOF/EOL flags and status counters.
module vid_stream_pkr
   import vid_stream_pkr_pkg::*;
#(
   parameter int unsigned PW      = 8,
   parameter int unsigned FIFO_AW = 4,
   parameter int unsigned CNT_W   = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hs,
   input  logic              vs,
   input  logic              vld,
   input  logic [3*PW-1:0]   rgb,
   output logic [3*PW-1:0]   m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tuser,
   output logic              m_tlast,
   output logic [CNT_W-1:0]  act_width,
   output logic [CNT_W-1:0]  act_height,
   output logic [15:0]       frame_cnt,
   input  logic              ovf_clr,
   output logic              ovf_sticky,
   output logic [15:0]       drop_cnt
);

   localparam int unsigned PIX_W = 3*PW;
   localparam int unsigned ENT_W = PIX_W + FLAG_W;

   vidState_t        state, stateNxt;
   logic             vsD, vldD, vsRise, vldFall;
   logic             holdValid, holdSof;
   logic [PIX_W-1:0] holdPix;
   logic [CNT_W-1:0] pixCnt, lineCnt;
   logic             accept, sofTag, frameDone;
   logic             eol, flush, push, pop, drop, fifoFull;
   logic [ENT_W-1:0] pushData, popData;
   logic             unusedHs;

   // hs carries no framing information for this block
   assign unusedHs = hs;

   assign vsRise  = vs & ~vsD;
   assign vldFall = ~vld & vldD;
   assign eol     = vldFall & holdValid;
   assign flush   = accept & holdValid;
   assign push    = eol | flush;
   assign pop     = m_tvalid & m_tready;
   assign drop    = push & fifoFull & ~pop;

   always_ff @(posedge clk) begin
      if (rst) state <= WAIT_VS;
      else     state <= stateNxt;
   end

   // A vs edge coinciding with a valid pixel makes that pixel the SOF of the new frame
   always_comb begin
      stateNxt  = state;
      accept    = 1'b0;
      sofTag    = 1'b0;
      frameDone = 1'b0;
      unique case (state)
         WAIT_VS: begin
            if (vsRise) begin
               stateNxt = WAIT_SOF;
               if (vld) begin
                  accept   = 1'b1;
                  sofTag   = 1'b1;
                  stateNxt = ACTIVE;
               end
            end
         end
         WAIT_SOF: begin
            if (vld) begin
               accept   = 1'b1;
               sofTag   = 1'b1;
               stateNxt = ACTIVE;
            end
         end
         ACTIVE: begin
            if (vsRise) begin
               frameDone = 1'b1;
               stateNxt  = WAIT_SOF;
            end
            if (vld) begin
               accept   = 1'b1;
               sofTag   = vsRise;
               stateNxt = ACTIVE;
            end
         end
         default: stateNxt = WAIT_VS;
      endcase
   end

   always_comb begin
      pushData                       = '0;
      pushData[PIX_W-1:0]            = holdPix;
      pushData[PIX_W + TLAST_OFS]    = eol;
      pushData[PIX_W + TUSER_OFS]    = holdSof;
   end

   // Hold register delays each pixel one beat so tlast is known when it is written
   always_ff @(posedge clk) begin
      if (rst) begin
         vsD        <= 1'b0;
         vldD       <= 1'b0;
         holdValid  <= 1'b0;
         holdSof    <= 1'b0;
         holdPix    <= '0;
         pixCnt     <= '0;
         lineCnt    <= '0;
         act_width  <= '0;
         act_height <= '0;
         frame_cnt  <= '0;
         ovf_sticky <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         vsD  <= vs;
         vldD <= vld;

         if (accept) begin
            holdValid <= 1'b1;
            holdSof   <= sofTag;
            holdPix   <= rgb;
         end else if (eol) begin
            holdValid <= 1'b0;
         end

         if (eol) begin
            act_width <= pixCnt;
            pixCnt    <= '0;
         end else if (accept) begin
            pixCnt <= (vsRise ? '0 : pixCnt) + CNT_W'(1);
         end else if (vsRise) begin
            pixCnt <= '0;
         end

         if (vsRise)   lineCnt <= '0;
         else if (eol) lineCnt <= lineCnt + CNT_W'(1);

         // A line ending on the same cycle as vs still counts toward this frame
         if (frameDone) begin
            act_height <= lineCnt + CNT_W'(eol);
            frame_cnt  <= frame_cnt + 16'd1;
         end

         if (drop) begin
            ovf_sticky <= 1'b1;
            drop_cnt   <= ovf_clr ? 16'd1 : satInc16(drop_cnt);
         end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
            drop_cnt   <= '0;
         end
      end
   end

   vid_stream_pkr_sfifo #(
      .WIDTH (ENT_W),
      .AW    (FIFO_AW)
   ) uFifo (
      .clk    (clk),
      .rst    (rst),
      .push   (push),
      .wrData (pushData),
      .pop    (pop),
      .rdData (popData),
      .valid  (m_tvalid),
      .full   (fifoFull)
   );

   assign m_tdata = popData[PIX_W-1:0];
   assign m_tlast = popData[PIX_W + TLAST_OFS];
   assign m_tuser = popData[PIX_W + TUSER_OFS];

endmodule

// File: tb/tb_vid_stream_pkr.sv
// Bench for vid_stream_pkr: two instances (4- and 16-deep FIFO) against a queue-based stream model.
module tb_vid_stream_pkr;

   localparam int unsigned PW    = 8;
   localparam int unsigned CNT_W = 12;
   localparam int unsigned PIX_W = 3*PW;
   localparam int unsigned ENT_W = PIX_W + 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, hs, vs, vld, ovfClr;
   logic [PIX_W-1:0] rgb;
   logic             trdy [2];
   logic [PIX_W-1:0] tdata [2];
   logic             tvalid [2], tuser [2], tlast [2], sticky [2];
   logic [CNT_W-1:0] aw [2], ah [2];
   logic [15:0]      fc [2], dc [2];

   logic trA, rndB;

   vid_stream_pkr #(.PW(PW), .FIFO_AW(2), .CNT_W(CNT_W)) dutA (
      .clk(clk), .rst(rst), .hs(hs), .vs(vs), .vld(vld), .rgb(rgb),
      .m_tdata(tdata[0]), .m_tvalid(tvalid[0]), .m_tready(trdy[0]),
      .m_tuser(tuser[0]), .m_tlast(tlast[0]),
      .act_width(aw[0]), .act_height(ah[0]), .frame_cnt(fc[0]),
      .ovf_clr(ovfClr), .ovf_sticky(sticky[0]), .drop_cnt(dc[0]));

   vid_stream_pkr #(.PW(PW), .FIFO_AW(4), .CNT_W(CNT_W)) dutB (
      .clk(clk), .rst(rst), .hs(hs), .vs(vs), .vld(vld), .rgb(rgb),
      .m_tdata(tdata[1]), .m_tvalid(tvalid[1]), .m_tready(trdy[1]),
      .m_tuser(tuser[1]), .m_tlast(tlast[1]),
      .act_width(aw[1]), .act_height(ah[1]), .frame_cnt(fc[1]),
      .ovf_clr(ovfClr), .ovf_sticky(sticky[1]), .drop_cnt(dc[1]));

   int passed = 0;
   int total  = 0;

   task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, d, got, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int               depth [2] = '{4, 16};
   logic             pvs, pvld, armed, started, hv, hsof;
   logic [PIX_W-1:0] hp;
   int               pc, lc;
   logic [CNT_W-1:0] mW, mH;
   logic [15:0]      mF;
   logic [ENT_W-1:0] qbuf [2][16];
   int               qh [2], qn [2];
   logic             mSticky [2];
   logic [15:0]      mDrop [2];
   logic [ENT_W-1:0] logA [$];
   logic [ENT_W-1:0] logB [$];

   task automatic modelReset();
      pvs = 0; pvld = 0; armed = 0; started = 0; hv = 0; hsof = 0; hp = '0;
      pc = 0; lc = 0; mW = '0; mH = '0; mF = '0;
      for (int d = 0; d < 2; d++) begin
         qh[d] = 0; qn[d] = 0; mSticky[d] = 0; mDrop[d] = '0;
      end
   endtask

   task automatic modelStep();
      logic             vsR, vF, pushE, dropped;
      logic [ENT_W-1:0] ent;
      if (rst) begin
         modelReset();
         return;
      end
      vsR = vs && !pvs;
      vF  = !vld && pvld;
      pvs = vs; pvld = vld;
      pushE = 0; ent = '0;
      // order of events: end-of-line, then frame boundary, then the new pixel
      if (vF && hv) begin
         pushE = 1; ent = {hsof, 1'b1, hp};
         mW = CNT_W'(pc); pc = 0; lc++; hv = 0;
      end
      if (vsR) begin
         if (started) begin
            mH = CNT_W'(lc); mF = mF + 16'd1;
         end
         lc = 0; pc = 0; armed = 1; started = 0;
      end
      if (vld && armed) begin
         if (hv) begin
            pushE = 1; ent = {hsof, 1'b0, hp};
         end
         hp = rgb; hsof = !started; hv = 1; pc++; started = 1;
      end
      for (int d = 0; d < 2; d++) begin
         if (qn[d] > 0 && trdy[d]) begin
            qh[d] = (qh[d] + 1) % 16; qn[d]--;
         end
         dropped = pushE && (qn[d] >= depth[d]);
         if (pushE && !dropped) begin
            qbuf[d][(qh[d] + qn[d]) % 16] = ent; qn[d]++;
         end
         if (dropped) begin
            mSticky[d] = 1;
            mDrop[d]   = ovfClr ? 16'd1 : ((mDrop[d] == 16'hFFFF) ? mDrop[d] : mDrop[d] + 16'd1);
         end else if (ovfClr) begin
            mSticky[d] = 0; mDrop[d] = '0;
         end
      end
   endtask

   // compare, log accepted beats, then advance the model with this cycle's inputs
   always @(negedge clk) begin
      logic [ENT_W-1:0] e;
      for (int d = 0; d < 2; d++) begin
         chk("tvalid", d, 32'(tvalid[d]), 32'(qn[d] != 0));
         if (qn[d] != 0) begin
            e = qbuf[d][qh[d]];
            chk("tdata", d, 32'(tdata[d]), 32'(e[PIX_W-1:0]));
            chk("tlast", d, 32'(tlast[d]), 32'(e[PIX_W]));
            chk("tuser", d, 32'(tuser[d]), 32'(e[PIX_W+1]));
         end
         chk("ovf_sticky", d, 32'(sticky[d]), 32'(mSticky[d]));
         chk("drop_cnt",   d, 32'(dc[d]),     32'(mDrop[d]));
         chk("act_width",  d, 32'(aw[d]),     32'(mW));
         chk("act_height", d, 32'(ah[d]),     32'(mH));
         chk("frame_cnt",  d, 32'(fc[d]),     32'(mF));
      end
      if (tvalid[0] && trdy[0]) logA.push_back({tuser[0], tlast[0], tdata[0]});
      if (tvalid[1] && trdy[1]) logB.push_back({tuser[1], tlast[1], tdata[1]});
      modelStep();
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic v, input logic d);
      vs  = v;
      vld = d;
      hs  = ~d;
      rgb = d ? PIX_W'($urandom) : '0;
      trdy[0] = trA;
      trdy[1] = rndB ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0);
   endtask

   task automatic vsPulse();
      drive(1, 0); drive(1, 0);
      idle(3);
   endtask

   task automatic lines(input int w, input int h, input bit merge, input int hb);
      for (int l = 0; l < h; l++) begin
         for (int p = 0; p < w; p++) drive(0, 1);
         if (!(merge && l == h - 1)) idle(hb);
      end
   endtask

   logic [15:0] fcPrev;
   logic [ENT_W-1:0] b;

   initial begin
      modelReset();
      rst = 1; ovfClr = 0; trA = 1; rndB = 0;
      hs = 0; vs = 0; vld = 0; rgb = '0; trdy[0] = 1; trdy[1] = 1;
      idle(3);
      chk("reset tvalid", 1, 32'(tvalid[1]), 32'd0);
      chk("reset frame_cnt", 1, 32'(fc[1]), 32'd0);
      rst = 0;
      idle(2);

      // 1: 4x3 frame, sink always ready
      logB.delete();
      vsPulse();
      lines(4, 3, 0, 3);
      vsPulse();
      idle(4);
      chk("t1 beats", 1, 32'(logB.size()), 32'd12);
      for (int i = 0; i < 12; i++) begin
         if (i < logB.size()) begin
            b = logB[i];
            chk("t1 tuser", i, 32'(b[PIX_W+1]), 32'(i == 0));
            chk("t1 tlast", i, 32'(b[PIX_W]), 32'((i % 4) == 3));
         end
      end
      chk("t1 act_width", 1, 32'(aw[1]), 32'd4);
      chk("t1 act_height", 1, 32'(ah[1]), 32'd3);
      chk("t1 frame_cnt", 1, 32'(fc[1]), 32'd1);

      // 2: reset released mid-frame
      vsPulse();
      lines(4, 1, 0, 3);
      drive(0, 1); drive(0, 1);
      rst = 1;
      drive(0, 1); drive(0, 1);
      rst = 0;
      logB.delete();
      drive(0, 1); drive(0, 1);
      idle(3);
      lines(4, 1, 0, 3);
      idle(3);
      chk("t2 beats before vs", 1, 32'(logB.size()), 32'd0);
      vsPulse();
      lines(4, 2, 0, 3);
      vsPulse();
      idle(6);
      chk("t2 beats", 1, 32'(logB.size()), 32'd8);
      if (logB.size() > 0) begin
         b = logB[0];
         chk("t2 first tuser", 1, 32'(b[PIX_W+1]), 32'd1);
      end

      // 3: 4-deep FIFO stalled for 20 cycles under an 8-pixel line
      logA.delete();
      trA = 0;
      vsPulse();
      lines(8, 1, 0, 3);
      idle(4);
      trA = 1;
      idle(6);
      chk("t3 beats kept", 0, 32'(logA.size()), 32'd4);
      chk("t3 ovf_sticky", 0, 32'(sticky[0]), 32'd1);
      chk("t3 drop_cnt", 0, 32'(dc[0]), 32'd4);

      // 4: clear, then a clean frame
      ovfClr = 1;
      drive(0, 0);
      ovfClr = 0;
      idle(2);
      chk("t4 ovf_sticky", 0, 32'(sticky[0]), 32'd0);
      chk("t4 drop_cnt", 0, 32'(dc[0]), 32'd0);
      vsPulse();
      lines(4, 2, 0, 3);
      vsPulse();
      idle(4);
      chk("t4 clean sticky", 0, 32'(sticky[0]), 32'd0);
      chk("t4 clean drop_cnt", 0, 32'(dc[0]), 32'd0);

      // 5: last vld falls on the same cycle vs rises
      logB.delete();
      lines(3, 2, 1, 3);
      fcPrev = fc[1];
      vsPulse();
      idle(4);
      chk("t5 beats", 1, 32'(logB.size()), 32'd6);
      if (logB.size() > 0) begin
         b = logB[logB.size() - 1];
         chk("t5 last tlast", 1, 32'(b[PIX_W]), 32'd1);
      end
      chk("t5 act_height", 1, 32'(ah[1]), 32'd2);
      chk("t5 act_width", 1, 32'(aw[1]), 32'd3);
      chk("t5 frame_cnt", 1, 32'(fc[1]), 32'(fcPrev + 16'd1));

      // 6: three 16x8 frames with a 50% ready sink on the 16-deep instance
      logB.delete();
      rndB = 1;
      fcPrev = fc[1];
      for (int f = 0; f < 3; f++) begin
         lines(16, 8, 0, 32);
         vsPulse();
      end
      rndB = 0;
      idle(40);
      chk("t6 frame_cnt", 1, 32'(fc[1]), 32'(fcPrev + 16'd3));
      chk("t6 drop_cnt", 1, 32'(dc[1]), 32'd0);
      chk("t6 ovf_sticky", 1, 32'(sticky[1]), 32'd0);
      chk("t6 beats", 1, 32'(logB.size()), 32'd384);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
